// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory access controller.
// Holds access-size/strobe types, FSM states and lane/alignment helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input msize_t size,
                                           input logic [2:0] addr);
        logic mis;
        mis = 1'b0;
        unique case (size)
            MSIZE2:  mis = addr[0];
            MSIZE4:  mis = |addr[1:0];
            MSIZE8:  mis = |addr[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Low address bits below the access size are dropped, so a
    // misaligned access lands on the size-aligned lane.
    function automatic logic [2:0] lane_offset(input msize_t size,
                                               input logic [2:0] addr);
        logic [2:0] off;
        off = 3'd0;
        unique case (size)
            MSIZE1:  off = addr;
            MSIZE2:  off = {addr[2:1], 1'b0};
            MSIZE4:  off = {addr[2], 2'b00};
            default: off = 3'd0;
        endcase
        return off;
    endfunction

    function automatic strobe_t size_mask(input msize_t size);
        strobe_t m;
        m = 8'h00;
        unique case (size)
            MSIZE1:  m = 8'h01;
            MSIZE2:  m = 8'h03;
            MSIZE4:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load lane extraction: picks the addressed lane from doubleword bus data,
// right-aligns it and sign- or zero-extends it to 64 bits.
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  msize_t      size,
    input  logic        is_unsigned,
    input  logic [2:0]  addr,
    input  logic [63:0] data,
    output logic [63:0] result
);

    logic [63:0] lane;

    assign lane = data >> {lane_offset(size, addr), 3'b000};

    always_comb begin
        result = lane;
        unique case (size)
            MSIZE1: result = is_unsigned ? {56'd0, lane[7:0]}
                                         : {{56{lane[7]}}, lane[7:0]};
            MSIZE2: result = is_unsigned ? {48'd0, lane[15:0]}
                                         : {{48{lane[15]}}, lane[15:0]};
            MSIZE4: result = is_unsigned ? {32'd0, lane[31:0]}
                                         : {{32{lane[31]}}, lane[31:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller between pipeline and data bus.
// Optional MISALIGN_EXC_EN: misaligned accesses fault instead of going to the bus.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  msize_t      req_msize,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misalign,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output msize_t      dreq_size,
    output strobe_t     dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data
);

    state_t      state, state_nxt;
    logic        accept, misalign_now, busy;
    logic        is_store_q, unsigned_q;
    msize_t      msize_q;
    logic [63:0] addr_q, wdata_q, rdata_q, ext, wmask;
    logic [2:0]  off;

`ifdef MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign_now = is_misaligned(req_msize, req_addr[2:0]);
`else
    assign misalign_now = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = misalign_now ? RESP : BUSY;
            BUSY:    if (dresp_data_ok) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q <= 1'b0;
            unsigned_q <= 1'b0;
            msize_q    <= MSIZE1;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            rdata_q    <= 64'd0;
        end else if (accept) begin
            is_store_q <= req_is_store;
            unsigned_q <= req_unsigned;
            msize_q    <= req_msize;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= 64'd0;
        end else if (state == BUSY && dresp_data_ok) begin
            rdata_q <= is_store_q ? 64'd0 : ext;
        end
    end

`ifdef MISALIGN_EXC_EN
    always_ff @(posedge clk) begin
        if (reset)       misalign_q <= 1'b0;
        else if (accept) misalign_q <= misalign_now;
    end
    assign resp_misalign = resp_valid && misalign_q;
`else
    assign resp_misalign = 1'b0;
`endif

    load_extend u_load_extend (
        .size        (msize_q),
        .is_unsigned (unsigned_q),
        .addr        (addr_q[2:0]),
        .data        (dresp_data),
        .result      (ext)
    );

    always_comb begin
        wmask = 64'hFFFF_FFFF_FFFF_FFFF;
        unique case (msize_q)
            MSIZE1:  wmask = 64'h0000_0000_0000_00FF;
            MSIZE2:  wmask = 64'h0000_0000_0000_FFFF;
            MSIZE4:  wmask = 64'h0000_0000_FFFF_FFFF;
            default: wmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign off  = lane_offset(msize_q, addr_q[2:0]);
    assign busy = (state == BUSY) && !reset;

    assign dreq_valid  = busy;
    assign dreq_addr   = busy ? addr_q : 64'd0;
    assign dreq_size   = busy ? msize_q : MSIZE1;
    assign dreq_strobe = (busy && is_store_q) ? (size_mask(msize_q) << off) : 8'h00;
    assign dreq_data   = (busy && is_store_q) ? ((wdata_q & wmask) << {off, 3'b000})
                                              : 64'd0;

    assign resp_valid = (state == RESP) && !reset;
    assign resp_rdata = resp_valid ? rdata_q : 64'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table plus corner sequences.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk, reset, req_valid, req_ready, req_is_store, req_unsigned;
    msize_t      req_msize, dreq_size;
    logic [63:0] req_addr, req_wdata, resp_rdata, dreq_addr, dreq_data, dresp_data;
    logic        resp_valid, resp_misalign, dreq_valid, dresp_data_ok;
    strobe_t     dreq_strobe;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_msize(req_msize),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        msize_t      sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] bus;
        strobe_t     strobe;
        logic [63:0] data;
        logic [63:0] rdata;
        int          dly;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errs   = 0;
    vec_t vecs[12];

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic st, msize_t sz, logic uns,
                                logic [63:0] addr, logic [63:0] wdata,
                                logic [63:0] bus, strobe_t strobe,
                                logic [63:0] data, logic [63:0] rdata, int dly);
        vec_t v;
        v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.bus = bus; v.strobe = strobe; v.data = data; v.rdata = rdata;
        v.dly = dly;
        return v;
    endfunction

    function automatic logic exc_mis(msize_t sz, logic [63:0] addr);
`ifdef MISALIGN_EXC_EN
        return is_misaligned(sz, addr[2:0]);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: every completion must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_misalign", {63'd0, resp_misalign}, {63'd0, e.mis});
            end
        end
    end

    task automatic drive(input vec_t v);
        req_is_store = v.st;
        req_msize    = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.mis   = exc_mis(v.sz, v.addr);
        e.rdata = e.mis ? 64'd0 : v.rdata;
        sb.push_back(e);
    endtask

    task automatic do_req(input vec_t v);
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        push(v);
        @(negedge clk);
        req_valid = 1'b0;
        if (exc_mis(v.sz, v.addr)) begin
            chk("exc_no_dreq", {63'd0, dreq_valid}, 64'd0);
            chk("exc_resp_1cyc", {63'd0, resp_valid}, 64'd1);
        end else begin
            chk("dreq_valid", {63'd0, dreq_valid}, 64'd1);
            chk("dreq_addr", dreq_addr, v.addr);
            chk("dreq_size", {62'd0, dreq_size}, {62'd0, v.sz});
            for (int i = 0; i < v.dly; i++) begin
                chk("busy_strobe", {56'd0, dreq_strobe}, {56'd0, v.strobe});
                chk("busy_data", dreq_data, v.data);
                chk("busy_ready", {63'd0, req_ready}, 64'd0);
                chk("busy_no_resp", {63'd0, resp_valid}, 64'd0);
                @(negedge clk);
            end
            chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, v.strobe});
            chk("dreq_data", dreq_data, v.data);
            dresp_data_ok = 1'b1;
            dresp_data    = v.bus;
            @(negedge clk);
            dresp_data_ok = 1'b0;
            dresp_data    = {$urandom, $urandom};
            chk("resp_valid", {63'd0, resp_valid}, 64'd1);
        end
        @(negedge clk);
        chk("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        chk("ready_after_resp", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        vec_t a, b;
        vecs[0]  = mk(1, MSIZE1, 0, 64'h1003, 64'hAB, 64'h0, 8'h08,
                      64'hAB00_0000, 64'h0, 3);
        vecs[1]  = mk(0, MSIZE2, 0, 64'h2002, 64'hFFFF, 64'h8001_0000, 8'h00,
                      64'h0, 64'hFFFF_FFFF_FFFF_8001, 1);
        vecs[2]  = mk(0, MSIZE2, 1, 64'h2002, 64'hFFFF, 64'h8001_0000, 8'h00,
                      64'h0, 64'h8001, 0);
        vecs[3]  = mk(0, MSIZE1, 0, 64'h5007, 64'hFFFF, 64'h8000_0000_0000_0011,
                      8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 2);
        vecs[4]  = mk(0, MSIZE1, 1, 64'h5007, 64'hFFFF, 64'h8000_0000_0000_0011,
                      8'h00, 64'h0, 64'h80, 0);
        vecs[5]  = mk(0, MSIZE4, 0, 64'h6004, 64'hFFFF, 64'h89AB_CDEF_0123_4567,
                      8'h00, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1);
        vecs[6]  = mk(0, MSIZE4, 1, 64'h6004, 64'hFFFF, 64'h89AB_CDEF_0123_4567,
                      8'h00, 64'h0, 64'h89AB_CDEF, 0);
        vecs[7]  = mk(0, MSIZE8, 0, 64'h7000, 64'hFFFF, 64'hDEAD_BEEF_CAFE_F00D,
                      8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 2);
        vecs[8]  = mk(1, MSIZE2, 0, 64'h8006, 64'hFFFF_1234, 64'h0, 8'hC0,
                      64'h1234_0000_0000_0000, 64'h0, 0);
        vecs[9]  = mk(1, MSIZE4, 0, 64'h9004, 64'h1122_3344_5566_7788, 64'h0,
                      8'hF0, 64'h5566_7788_0000_0000, 64'h0, 1);
        vecs[10] = mk(1, MSIZE8, 0, 64'h3000, 64'h0123_4567_89AB_CDEF, 64'h0,
                      8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 10);
        vecs[11] = mk(0, MSIZE4, 0, 64'h4002, 64'hFFFF, 64'h1122_3344_5566_7788,
                      8'h00, 64'h0, 64'h5566_7788, 1);

        reset = 1'b1; req_valid = 1'b0; dresp_data_ok = 1'b0;
        dresp_data = 64'd0;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

        // Stray bus completion while idle must not produce a response.
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("idle_ok_ignored", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("idle_ok_no_resp", {63'd0, resp_valid}, 64'd0);

        for (int i = 0; i < 12; i++) do_req(vecs[i]);

        // Back-to-back with req_valid held high.
        a = vecs[4];
        b = mk(1, MSIZE1, 0, 64'hC005, 64'h5A, 64'h0, 8'h20,
               64'h5A00_0000_0000, 64'h0, 0);
        @(negedge clk);
        drive(a);
        req_valid = 1'b1;
        chk("b2b_ready_a", {63'd0, req_ready}, 64'd1);
        push(a);
        @(negedge clk);
        drive(b);
        push(b);
        chk("b2b_dreq_a", {63'd0, dreq_valid}, 64'd1);
        dresp_data_ok = 1'b1;
        dresp_data   = a.bus;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("b2b_resp_a", {63'd0, resp_valid}, 64'd1);
        chk("b2b_ready_in_resp", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("b2b_ready_b", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_dreq_b", {63'd0, dreq_valid}, 64'd1);
        chk("b2b_strobe_b", {56'd0, dreq_strobe}, 64'h20);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("b2b_resp_b", {63'd0, resp_valid}, 64'd1);
        @(negedge clk);
        chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in BUSY abandons the request.
        drive(vecs[7]);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rb_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rb_dreq_dropped", {63'd0, dreq_valid}, 64'd0);
        chk("rb_ready_low", {63'd0, req_ready}, 64'd0);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("rb_ready_release", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rb_no_resp", {63'd0, resp_valid}, 64'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
